cpu_ctrl_seq: RTL and testbench

- Instruction sequencer and control unit that sits directly upstream of the ALU.
- Fetches 8-bit instructions from a synchronous program memory and decodes them.
- Drives the ALU function select f, write_cz, and the A/B register load enables and bus-source select in the datapath.
- Consumes the ALU's registered CF/ZF flags to resolve conditional jumps. Fixed 3-cycle FETCH/DECODE/EXECUTE per instruction.

---
 rtl/cpu_ctrl_seq.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_seq.sv
// Instruction sequencer / control unit for the ALU datapath: FETCH, DECODE, EXECUTE per instruction.
// Optional single-step mode (step input, PAUSE state) is enabled by defining SINGLE_STEP_EN.
module cpu_ctrl_seq #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic [3:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_rdata,
    input  logic       CF_in,
    input  logic       ZF_in,
    output logic [2:0] f,
    output logic       write_cz,
    output logic       ld_a,
    output logic       ld_b,
    output logic       imm_sel,
    output logic [3:0] imm,
    output logic       out_en,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StHalt,
        StPause
    } state_e;

    typedef enum logic [3:0] {
        OpNop  = 4'h0,
        OpLdi  = 4'h1,
        OpMovb = 4'h2,
        OpInca = 4'h3,
        OpIncb = 4'h4,
        OpAdd  = 4'h5,
        OpSub  = 4'h6,
        OpAnd  = 4'h7,
        OpOr   = 4'h8,
        OpJmp  = 4'h9,
        OpJc   = 4'hA,
        OpJz   = 4'hB,
        OpJnz  = 4'hC,
        OpOut  = 4'hD,
        OpRsvd = 4'hE,
        OpHlt  = 4'hF
    } opcode_e;

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;

    opcode_e    opcode;
    logic [2:0] dec_f;
    logic       dec_write_cz;
    logic       dec_ld_a;
    logic       dec_ld_b;
    logic       dec_imm_sel;
    logic       dec_out_en;
    logic       dec_jump;
    logic       dec_halt;

    assign opcode = opcode_e'(ir_q[7:4]);

    // Pure instruction decode; only takes effect while in EXECUTE.
    always_comb begin
        dec_f        = 3'b000;
        dec_write_cz = 1'b0;
        dec_ld_a     = 1'b0;
        dec_ld_b     = 1'b0;
        dec_imm_sel  = 1'b0;
        dec_out_en   = 1'b0;
        dec_jump     = 1'b0;
        dec_halt     = 1'b0;
        unique case (opcode)
            OpNop: ;
            OpLdi: begin
                dec_f        = 3'b001;
                dec_imm_sel  = 1'b1;
                dec_ld_a     = 1'b1;
                dec_write_cz = 1'b1;
            end
            OpMovb: begin
                dec_f    = 3'b000;
                dec_ld_b = 1'b1;
            end
            OpInca: begin
                dec_f        = 3'b010;
                dec_ld_a     = 1'b1;
                dec_write_cz = 1'b1;
            end
            OpIncb: begin
                dec_f        = 3'b011;
                dec_ld_b     = 1'b1;
                dec_write_cz = 1'b1;
            end
            OpAdd: begin
                dec_f        = 3'b100;
                dec_ld_a     = 1'b1;
                dec_write_cz = 1'b1;
            end
            OpSub: begin
                dec_f        = 3'b101;
                dec_ld_a     = 1'b1;
                dec_write_cz = 1'b1;
            end
            OpAnd: begin
                dec_f        = 3'b110;
                dec_ld_a     = 1'b1;
                dec_write_cz = 1'b1;
            end
            OpOr: begin
                dec_f        = 3'b111;
                dec_ld_a     = 1'b1;
                dec_write_cz = 1'b1;
            end
            OpJmp:  dec_jump = 1'b1;
            OpJc:   dec_jump = CF_in;
            OpJz:   dec_jump = ZF_in;
            OpJnz:  dec_jump = ~ZF_in;
            OpOut:  dec_out_en = 1'b1;
            OpRsvd: ;
            OpHlt:  dec_halt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mem_addr = pc_q;
        imm      = ir_q[3:0];
        mem_rd   = 1'b0;
        f        = 3'b000;
        write_cz = 1'b0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        imm_sel  = 1'b0;
        out_en   = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                busy    = 1'b1;
                mem_rd  = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                busy    = 1'b1;
                ir_d    = mem_rdata;
                pc_d    = pc_q + 4'd1;
                state_d = StExecute;
            end
            StExecute: begin
                busy     = 1'b1;
                f        = dec_f;
                write_cz = dec_write_cz;
                ld_a     = dec_ld_a;
                ld_b     = dec_ld_b;
                imm_sel  = dec_imm_sel;
                out_en   = dec_out_en;
                // A taken jump replaces the increment done in DECODE.
                if (dec_jump) begin
                    pc_d = ir_q[3:0];
                end
                if (dec_halt) begin
                    state_d = StHalt;
                end else begin
`ifdef SINGLE_STEP_EN
                    state_d = StPause;
`else
                    state_d = StFetch;
`endif
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
`ifdef SINGLE_STEP_EN
            StPause: begin
                if (step) begin
                    state_d = StFetch;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: a reference sequencer model fills expected fetch
// addresses and EXECUTE control words into queues, which are popped as the DUT runs.
module tb_cpu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata = 8'h00;
    logic       CF_in = 1'b0;
    logic       ZF_in = 1'b0;
    logic [2:0] f;
    logic       write_cz, ld_a, ld_b, imm_sel, out_en, busy, halted;
    logic [3:0] imm;
`ifdef SINGLE_STEP_EN
    logic       step = 1'b1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit spam = 1'b0;

    logic [7:0]  prog [16];
    logic [3:0]  exp_addr_q [$];
    logic [13:0] exp_ctrl_q [$];

    cpu_ctrl_seq #(.RESET_PC(4'h0)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
`ifdef SINGLE_STEP_EN
        .step     (step),
`endif
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_rdata(mem_rdata),
        .CF_in    (CF_in),
        .ZF_in    (ZF_in),
        .f        (f),
        .write_cz (write_cz),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .imm_sel  (imm_sel),
        .imm      (imm),
        .out_en   (out_en),
        .busy     (busy),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= prog[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] dut_ctrl();
        return {f, write_cz, ld_a, ld_b, imm_sel, out_en, busy, halted, imm};
    endfunction

    // Expected EXECUTE-cycle outputs from the opcode table.
    function automatic logic [13:0] exp_ctrl(input logic [7:0] ins);
        logic [2:0] ef;
        logic wcz, la, lb, isel, oe;
        ef = 3'b000; wcz = 0; la = 0; lb = 0; isel = 0; oe = 0;
        case (ins[7:4])
            4'h1: begin ef = 3'b001; isel = 1; la = 1; wcz = 1; end
            4'h2: begin ef = 3'b000; lb = 1; end
            4'h3: begin ef = 3'b010; la = 1; wcz = 1; end
            4'h4: begin ef = 3'b011; lb = 1; wcz = 1; end
            4'h5: begin ef = 3'b100; la = 1; wcz = 1; end
            4'h6: begin ef = 3'b101; la = 1; wcz = 1; end
            4'h7: begin ef = 3'b110; la = 1; wcz = 1; end
            4'h8: begin ef = 3'b111; la = 1; wcz = 1; end
            4'hD: oe = 1;
            default: ;
        endcase
        return {ef, wcz, la, lb, isel, oe, 1'b1, 1'b0, ins[3:0]};
    endfunction

    task automatic tick();
        @(negedge clk);
        start = spam ? 1'($urandom) : 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
    endtask

    task automatic do_reset();
        spam = 1'b0;
        start = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ctrl", 32'(dut_ctrl()), 32'h0);
        check("reset_addr", 32'(mem_addr), 32'h0);
        check("reset_rd", 32'(mem_rd), 32'h0);
        rstn = 1'b1;
    endtask

    // Run n instructions from RESET_PC; stops early at HLT and then checks the halted state.
    task automatic run_prog(input int n, input bit do_spam);
        logic [3:0] pc;
        logic [7:0] ins;
        bit will_halt;
        pc = 4'h0;
        will_halt = 1'b0;
        for (int i = 0; i < n; i++) begin
            ins = prog[pc];
            exp_addr_q.push_back(pc);
            exp_ctrl_q.push_back(exp_ctrl(ins));
            pc = pc + 4'd1;
            case (ins[7:4])
                4'h9: pc = ins[3:0];
                4'hA: if (CF_in) pc = ins[3:0];
                4'hB: if (ZF_in) pc = ins[3:0];
                4'hC: if (!ZF_in) pc = ins[3:0];
                default: ;
            endcase
            if (ins[7:4] == 4'hF) begin
                will_halt = 1'b1;
                break;
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        spam = do_spam;
        check("fetch_latency", 32'(mem_rd), 32'h1);
        while (exp_addr_q.size() > 0) begin
            for (int c = 0; c < 10 && !mem_rd; c++) tick();
            check("fetch_rd", 32'(mem_rd), 32'h1);
            if (!mem_rd) begin
                exp_addr_q.delete();
                exp_ctrl_q.delete();
                break;
            end
            check("fetch_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            tick();
            tick();
            check("exec_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl_q.pop_front()));
        end
        if (will_halt) begin
            tick();
            check("halted", 32'({busy, halted, mem_rd}), 32'b010);
        end
        spam = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        bit fetched;
        clear_prog();

        // Straight-line program, start spammed while running.
        do_reset();
        prog[0] = 8'h15; prog[1] = 8'h30; prog[2] = 8'hD0; prog[3] = 8'hF0;
        run_prog(4, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("halt_sticky", 32'({halted, busy, mem_rd}), 32'b100);

        // Conditional jumps, taken and not taken.
        clear_prog();
        prog[0] = 8'hB7;
        ZF_in = 1'b1; do_reset(); run_prog(2, 1'b0);
        ZF_in = 1'b0; do_reset(); run_prog(2, 1'b0);
        prog[0] = 8'hA7;
        CF_in = 1'b1; do_reset(); run_prog(2, 1'b0);
        CF_in = 1'b0; do_reset(); run_prog(2, 1'b0);
        prog[0] = 8'hC7;
        ZF_in = 1'b0; do_reset(); run_prog(2, 1'b0);
        ZF_in = 1'b1; do_reset(); run_prog(2, 1'b0);
        ZF_in = 1'b0;

        // Mixed ALU ops and unconditional jump.
        clear_prog();
        prog[0] = 8'h2A; prog[1] = 8'h4B; prog[2] = 8'h5C; prog[3] = 8'h6D;
        prog[4] = 8'h7E; prog[5] = 8'h81; prog[6] = 8'hE3; prog[7] = 8'h9A;
        prog[10] = 8'h03;
        do_reset(); run_prog(10, 1'b1);

        // PC wrap from 0xF to 0x0.
        clear_prog();
        prog[0] = 8'h9F; prog[15] = 8'h00;
        do_reset(); run_prog(3, 1'b0);

        // Reset in the middle of an ADD EXECUTE.
        clear_prog();
        prog[0] = 8'h50;
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("add_exec", 32'(dut_ctrl()), 32'(exp_ctrl(8'h50)));
        #1 rstn = 1'b0;
        #1;
        check("rst_mid_ctrl", 32'({ld_a, write_cz, busy}), 32'b000);
        check("rst_mid_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        fetched = 1'b0;
        repeat (5) begin
            @(negedge clk);
            fetched |= mem_rd | busy;
        end
        check("no_fetch_after_rst", 32'(fetched), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
